// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and AXI4-Lite constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_PROT_DATA = 3'b010;
  localparam logic [2:0] AXI_PROT_INST = 3'b110;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - AXI4-Lite bundle; master modport drives requests, slave modport answers them
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// rtl/mem_port_arbiter_rr_arbiter_2.sv - 2-way arbiter; round-robin, or fixed M1 priority under ARB_FIXED_PRIORITY_EN
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] request,
  input  logic       advance,
  input  logic [1:0] served,
  output logic [1:0] grant
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused;
  assign unused = ^{clk, reset, advance, served};

  always_comb begin
    grant = request[1] ? 2'b10 : {1'b0, request[0]};
  end
`else
  // Set means M1 wins a tie; after serving a master the other one gets the tie.
  logic prio_m1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_m1 <= 1'b1;
    end else if (advance) begin
      prio_m1 <= served[0] & ~served[1];
    end
  end

  always_comb begin
    grant = request;
    if (request == 2'b11) begin
      grant = prio_m1 ? 2'b10 : 2'b01;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - 2:1 AXI4-Lite arbiter, fetch (M0) and data (M1) sharing one memory port
// Optional build macro: ARB_FIXED_PRIORITY_EN (fixed M1 priority instead of round-robin).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   m0_axi,
  mem_port_arbiter_if.slave   m1_axi,
  mem_port_arbiter_if.master  s_axi
);

  rd_state_t rd_state;
  wr_state_t wr_state;
  logic      rd_sel;
  logic      wr_sel;
  logic      aw_done;
  logic      w_done;

  logic [1:0] rd_req, wr_req, rd_grant, wr_grant;
  logic       rd_addr_hs, rd_resp_hs, aw_hs, w_hs, wr_resp_hs;

  logic [ADDR_WIDTH-1:0]   rd_addr_mux;
  logic [ADDR_WIDTH-1:0]   wr_addr_mux;
  logic [DATA_WIDTH-1:0]   wr_data_mux;
  logic [DATA_WIDTH/8-1:0] wr_strb_mux;

  // W may arrive before AW, so either channel counts as a write request.
  assign rd_req = {m1_axi.arvalid, m0_axi.arvalid};
  assign wr_req = {m1_axi.awvalid | m1_axi.wvalid, m0_axi.awvalid | m0_axi.wvalid};

  assign rd_addr_hs = s_axi.arvalid && s_axi.arready;
  assign rd_resp_hs = (rd_state == R_RESP) && s_axi.rvalid && s_axi.rready;
  assign aw_hs      = s_axi.awvalid && s_axi.awready;
  assign w_hs       = s_axi.wvalid && s_axi.wready;
  assign wr_resp_hs = (wr_state == W_RESP) && s_axi.bvalid && s_axi.bready;

  rr_arbiter_2 u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .request (rd_req),
    .advance (rd_resp_hs),
    .served  ({rd_sel, ~rd_sel}),
    .grant   (rd_grant)
  );

  rr_arbiter_2 u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .request (wr_req),
    .advance (wr_resp_hs),
    .served  ({wr_sel, ~wr_sel}),
    .grant   (wr_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_sel   <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: if (|rd_req) begin
          rd_sel   <= rd_grant[1];
          rd_state <= R_ADDR;
        end
        R_ADDR:  if (rd_addr_hs) rd_state <= R_RESP;
        R_RESP:  if (rd_resp_hs) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_sel   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (|wr_req) begin
          wr_sel   <= wr_grant[1];
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= W_DATA;
        end
        W_DATA: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            wr_state <= W_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP:  if (wr_resp_hs) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_addr_mux    = rd_sel ? m1_axi.araddr : m0_axi.araddr;
    s_axi.araddr   = '0;
    s_axi.arprot   = '0;
    s_axi.arvalid  = 1'b0;
    s_axi.rready   = 1'b0;
    m0_axi.arready = 1'b0;
    m0_axi.rdata   = '0;
    m0_axi.rresp   = '0;
    m0_axi.rvalid  = 1'b0;
    m1_axi.arready = 1'b0;
    m1_axi.rdata   = '0;
    m1_axi.rresp   = '0;
    m1_axi.rvalid  = 1'b0;
    if (rd_state == R_ADDR) begin
      s_axi.araddr  = rd_addr_mux;
      s_axi.arprot  = rd_sel ? m1_axi.arprot  : m0_axi.arprot;
      s_axi.arvalid = rd_sel ? m1_axi.arvalid : m0_axi.arvalid;
      if (rd_sel) m1_axi.arready = s_axi.arready;
      else        m0_axi.arready = s_axi.arready;
    end
    if (rd_state == R_RESP) begin
      s_axi.rready = rd_sel ? m1_axi.rready : m0_axi.rready;
      if (rd_sel) begin
        m1_axi.rdata  = s_axi.rdata;
        m1_axi.rresp  = s_axi.rresp;
        m1_axi.rvalid = s_axi.rvalid;
      end else begin
        m0_axi.rdata  = s_axi.rdata;
        m0_axi.rresp  = s_axi.rresp;
        m0_axi.rvalid = s_axi.rvalid;
      end
    end
  end

  always_comb begin
    wr_addr_mux    = wr_sel ? m1_axi.awaddr : m0_axi.awaddr;
    wr_data_mux    = wr_sel ? m1_axi.wdata  : m0_axi.wdata;
    wr_strb_mux    = wr_sel ? m1_axi.wstrb  : m0_axi.wstrb;
    s_axi.awaddr   = '0;
    s_axi.awprot   = '0;
    s_axi.awvalid  = 1'b0;
    s_axi.wdata    = '0;
    s_axi.wstrb    = '0;
    s_axi.wvalid   = 1'b0;
    s_axi.bready   = 1'b0;
    m0_axi.awready = 1'b0;
    m0_axi.wready  = 1'b0;
    m0_axi.bresp   = '0;
    m0_axi.bvalid  = 1'b0;
    m1_axi.awready = 1'b0;
    m1_axi.wready  = 1'b0;
    m1_axi.bresp   = '0;
    m1_axi.bvalid  = 1'b0;
    if (wr_state == W_DATA) begin
      // Completed channels are masked so each beat reaches the slave only once.
      s_axi.awaddr  = wr_addr_mux;
      s_axi.awprot  = wr_sel ? m1_axi.awprot : m0_axi.awprot;
      s_axi.awvalid = (wr_sel ? m1_axi.awvalid : m0_axi.awvalid) && !aw_done;
      s_axi.wdata   = wr_data_mux;
      s_axi.wstrb   = wr_strb_mux;
      s_axi.wvalid  = (wr_sel ? m1_axi.wvalid : m0_axi.wvalid) && !w_done;
      if (wr_sel) begin
        m1_axi.awready = s_axi.awready && !aw_done;
        m1_axi.wready  = s_axi.wready && !w_done;
      end else begin
        m0_axi.awready = s_axi.awready && !aw_done;
        m0_axi.wready  = s_axi.wready && !w_done;
      end
    end
    if (wr_state == W_RESP) begin
      s_axi.bready = wr_sel ? m1_axi.bready : m0_axi.bready;
      if (wr_sel) begin
        m1_axi.bresp  = s_axi.bresp;
        m1_axi.bvalid = s_axi.bvalid;
      end else begin
        m0_axi.bresp  = s_axi.bresp;
        m0_axi.bvalid = s_axi.bvalid;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   aw_hs_cnt = 0;
  int   w_hs_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .m0_axi (m0_if.slave),
    .m1_axi (m1_if.slave),
    .s_axi  (s_if.master)
  );

  always @(posedge clk) begin
    if (s_if.awvalid && s_if.awready) aw_hs_cnt++;
    if (s_if.wvalid && s_if.wready)   w_hs_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    m0_if.araddr = '0; m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 0;
    m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 0;
    m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wvalid = 0; m0_if.bready = 0;
    m1_if.araddr = '0; m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 0;
    m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 0;
    m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wvalid = 0; m1_if.bready = 0;
    s_if.arready = 0; s_if.rdata = '0; s_if.rresp = '0; s_if.rvalid = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bresp = '0; s_if.bvalid = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full single read by master mi, starting and ending on a falling edge.
  task automatic rd_single(input int mi, input logic [31:0] addr, input logic [31:0] data);
    if (mi == 0) begin
      m0_if.araddr = addr; m0_if.arprot = AXI_PROT_INST; m0_if.arvalid = 1; m0_if.rready = 1;
    end else begin
      m1_if.araddr = addr; m1_if.arprot = AXI_PROT_DATA; m1_if.arvalid = 1; m1_if.rready = 1;
    end
    #1 check("rd_arb_latency", s_if.arvalid, 0);
    @(negedge clk);
    check("rd_s_arvalid", s_if.arvalid, 1);
    check("rd_s_araddr", s_if.araddr, addr);
    check("rd_s_arprot", s_if.arprot, (mi == 0) ? AXI_PROT_INST : AXI_PROT_DATA);
    s_if.arready = 1;
    #1;
    check("rd_m_arready", (mi == 0) ? m0_if.arready : m1_if.arready, 1);
    check("rd_other_arready", (mi == 0) ? m1_if.arready : m0_if.arready, 0);
    @(negedge clk);
    m0_if.arvalid = 0; m1_if.arvalid = 0;
    s_if.arready = 0;
    s_if.rdata = data; s_if.rresp = AXI_RESP_OKAY; s_if.rvalid = 1;
    #1;
    check("rd_m_rvalid", (mi == 0) ? m0_if.rvalid : m1_if.rvalid, 1);
    check("rd_m_rdata", (mi == 0) ? m0_if.rdata : m1_if.rdata, data);
    check("rd_m_rresp", (mi == 0) ? m0_if.rresp : m1_if.rresp, AXI_RESP_OKAY);
    check("rd_other_rvalid", (mi == 0) ? m1_if.rvalid : m0_if.rvalid, 0);
    @(negedge clk);
    s_if.rvalid = 0;
    #1 check("rd_done_rvalid", (mi == 0) ? m0_if.rvalid : m1_if.rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:4] exp_order;
    logic [31:0] got_addr;
    int t;

`ifdef ARB_FIXED_PRIORITY_EN
    exp_order = 5'b11110;
`else
    exp_order = 5'b10100;
`endif

    // Reset state, with live-looking inputs present.
    idle_all();
    m0_if.arvalid = 1; m1_if.awvalid = 1; s_if.rvalid = 1; s_if.bvalid = 1; s_if.arready = 1;
    @(negedge clk);
    check("rst_s_arvalid", s_if.arvalid, 0);
    check("rst_s_awvalid", s_if.awvalid, 0);
    check("rst_m0_rvalid", m0_if.rvalid, 0);
    check("rst_m1_bvalid", m1_if.bvalid, 0);
    check("rst_m0_arready", m0_if.arready, 0);
    idle_all();
    reset = 1'b0;
    @(negedge clk);

    // Read routing to M0.
    rd_single(0, 32'h0000_0100, 32'hDEAD_BEEF);

    // Fairness: both masters hold arvalid; the fifth grant has only M0 left.
    pulse_reset();
    m0_if.araddr = 32'h1000; m0_if.arvalid = 1; m0_if.rready = 1;
    m1_if.araddr = 32'h2000; m1_if.arvalid = 1; m1_if.rready = 1;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      @(negedge clk);
      while (!s_if.arvalid && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("fair_ar_seen", s_if.arvalid, 1);
      got_addr = s_if.araddr;
      check("fair_grant", (got_addr == 32'h2000), exp_order[g]);
      s_if.arready = 1;
      @(negedge clk);
      s_if.arready = 0;
      s_if.rdata = 32'hF000 + g; s_if.rvalid = 1;
      #1;
      check("fair_rvalid_m1", m1_if.rvalid, exp_order[g]);
      check("fair_rvalid_m0", m0_if.rvalid, !exp_order[g]);
      @(negedge clk);
      s_if.rvalid = 0;
      if (g == 3) m1_if.arvalid = 0;
    end
    m0_if.arvalid = 0;
    @(negedge clk);

    // W before AW from M1.
    pulse_reset();
    aw_hs_cnt = 0; w_hs_cnt = 0;
    s_if.awready = 1; s_if.wready = 1;
    m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'hF; m1_if.wvalid = 1; m1_if.bready = 1;
    m0_if.bready = 1;
    #1 check("wfirst_idle_wvalid", s_if.wvalid, 0);
    @(negedge clk);
    check("wfirst_s_wvalid", s_if.wvalid, 1);
    check("wfirst_s_wdata", s_if.wdata, 32'h1234_5678);
    check("wfirst_s_wstrb", s_if.wstrb, 4'hF);
    check("wfirst_s_awvalid", s_if.awvalid, 0);
    check("wfirst_m1_wready", m1_if.wready, 1);
    @(negedge clk);
    check("wfirst_w_masked", s_if.wvalid, 0);
    check("wfirst_m1_wready_masked", m1_if.wready, 0);
    @(negedge clk);
    m1_if.wvalid = 0;
    m1_if.awaddr = 32'h2000; m1_if.awprot = AXI_PROT_DATA; m1_if.awvalid = 1;
    #1;
    check("wfirst_s_awvalid_late", s_if.awvalid, 1);
    check("wfirst_s_awaddr", s_if.awaddr, 32'h2000);
    check("wfirst_m1_awready", m1_if.awready, 1);
    @(negedge clk);
    m1_if.awvalid = 0;
    check("wfirst_aw_cleared", s_if.awvalid, 0);
    s_if.bresp = AXI_RESP_OKAY; s_if.bvalid = 1;
    #1;
    check("wfirst_m1_bvalid", m1_if.bvalid, 1);
    check("wfirst_m1_bresp", m1_if.bresp, AXI_RESP_OKAY);
    check("wfirst_m0_bvalid", m0_if.bvalid, 0);
    @(negedge clk);
    check("wfirst_back_idle", u_dut.wr_state, W_IDLE);
    #1 check("wfirst_idle_b_ignored", m1_if.bvalid, 0);
    s_if.bvalid = 0;
    check("wfirst_aw_once", aw_hs_cnt, 1);
    check("wfirst_w_once", w_hs_cnt, 1);

    // Parallel read (M0) and write (M1); write finishes first with SLVERR.
    pulse_reset();
    s_if.arready = 1; s_if.awready = 1; s_if.wready = 1;
    m0_if.araddr = 32'h40; m0_if.arvalid = 1; m0_if.rready = 1;
    m1_if.awaddr = 32'h80; m1_if.awvalid = 1;
    m1_if.wdata = 32'hA5A5_A5A5; m1_if.wstrb = 4'h3; m1_if.wvalid = 1; m1_if.bready = 1;
    @(negedge clk);
    check("par_s_arvalid", s_if.arvalid, 1);
    check("par_s_araddr", s_if.araddr, 32'h40);
    check("par_s_awvalid", s_if.awvalid, 1);
    check("par_s_awaddr", s_if.awaddr, 32'h80);
    check("par_s_wvalid", s_if.wvalid, 1);
    check("par_s_wstrb", s_if.wstrb, 4'h3);
    @(negedge clk);
    m0_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.arready = 0; s_if.awready = 0; s_if.wready = 0;
    s_if.bresp = AXI_RESP_SLVERR; s_if.bvalid = 1;
    #1;
    check("par_m1_bvalid", m1_if.bvalid, 1);
    check("par_m1_bresp", m1_if.bresp, AXI_RESP_SLVERR);
    check("par_m0_bvalid", m0_if.bvalid, 0);
    check("par_m0_rvalid_early", m0_if.rvalid, 0);
    @(negedge clk);
    s_if.bvalid = 0;
    s_if.rdata = 32'hCAFE_F00D; s_if.rresp = AXI_RESP_OKAY; s_if.rvalid = 1;
    #1;
    check("par_m0_rvalid", m0_if.rvalid, 1);
    check("par_m0_rdata", m0_if.rdata, 32'hCAFE_F00D);
    check("par_m1_rvalid", m1_if.rvalid, 0);
    @(negedge clk);
    s_if.rvalid = 0;

    // Slave backpressure on AR for five cycles.
    pulse_reset();
    m0_if.araddr = 32'h300; m0_if.arvalid = 1; m0_if.rready = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("bp_s_arvalid", s_if.arvalid, 1);
      check("bp_s_araddr", s_if.araddr, 32'h300);
      check("bp_m0_arready", m0_if.arready, 0);
    end
    @(negedge clk);
    s_if.arready = 1;
    #1 check("bp_m0_arready_hs", m0_if.arready, 1);
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0;
    check("bp_in_resp", u_dut.rd_state, R_RESP);
    s_if.rdata = 32'h0BAD_CAFE; s_if.rvalid = 1;
    #1 check("bp_m0_rdata", m0_if.rdata, 32'h0BAD_CAFE);
    @(negedge clk);
    s_if.rvalid = 0;

    // Reset while M0 sits in R_RESP; M1 was served last so M0 held the tie.
    pulse_reset();
    rd_single(1, 32'h500, 32'h11);
    m0_if.araddr = 32'h600; m0_if.arvalid = 1; m0_if.rready = 1;
    s_if.arready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rdata = 32'h22; s_if.rvalid = 1;
    #1 check("rstmid_m0_rvalid", m0_if.rvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_m0_rvalid_off", m0_if.rvalid, 0);
    check("rstmid_s_rready_off", s_if.rready, 0);
    check("rstmid_rd_idle", u_dut.rd_state, R_IDLE);
    s_if.rvalid = 0;
    @(negedge clk);
    reset = 1'b0;
    m0_if.araddr = 32'h600; m0_if.arvalid = 1;
    m1_if.araddr = 32'h700; m1_if.arvalid = 1;
    @(negedge clk);
    check("rstmid_s_arvalid", s_if.arvalid, 1);
    check("rstmid_grant_m1", s_if.araddr, 32'h700);
    pulse_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
